ht_cmd_initiator: RTL and testbench



---
 rtl/ht_cmd_initiator_if.sv | 34 +++
 rtl/ht_cmd_initiator.sv | 109 ++++++++++
 tb/tb_ht_cmd_initiator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ht_cmd_initiator_if.sv
// ht_cmd_initiator_if: request/response channels plus the hash-table command bus.
interface ht_cmd_initiator_if #(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 64
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [KEY_WIDTH-1:0]   req_key;
  logic [VALUE_WIDTH-1:0] req_value;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [1:0]             resp_status;
  logic [VALUE_WIDTH-1:0] resp_value;
  logic [15:0]            resp_cycles;
  logic [KEY_WIDTH-1:0]   ht_key;
  logic [VALUE_WIDTH-1:0] ht_value_in;
  logic                   ht_insert;
  logic                   ht_lookup;
  logic                   ht_erase;
  logic [VALUE_WIDTH-1:0] ht_value_out;
  logic                   ht_success;
  logic [1:0]             ht_state;
  modport master (
    input  req_valid, req_op, req_key, req_value, resp_ready, ht_value_out, ht_success, ht_state,
    output req_ready, resp_valid, resp_status, resp_value, resp_cycles,
           ht_key, ht_value_in, ht_insert, ht_lookup, ht_erase
  );
  modport slave (
    output req_valid, req_op, req_key, req_value, resp_ready, ht_value_out, ht_success, ht_state,
    input  req_ready, resp_valid, resp_status, resp_value, resp_cycles,
           ht_key, ht_value_in, ht_insert, ht_lookup, ht_erase
  );
endinterface

// File: rtl/ht_cmd_initiator.sv
// ht_cmd_initiator: sequences order-map requests into hash-table commands and returns status/value responses.
module ht_cmd_initiator #(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ht_cmd_initiator_if.master   bus,
  output logic [31:0]          op_count,
  output logic                 timeout_seen
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_ARM = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;
  localparam logic [1:0] OP_INS = 2'd0, OP_LK = 2'd1, OP_ER = 2'd2, OP_UPD = 2'd3;
  localparam logic [1:0] ST_OK = 2'd0, ST_MISS = 2'd1, ST_FULL = 2'd2, ST_TO = 2'd3;
  logic [1:0]             state, op, st_done;
  logic                   upd_ins, done;
  logic [VALUE_WIDTH-1:0] old_val, val_done;
  logic [15:0]            cnt, cur;
  logic [TW-1:0]          tmr, tmr_nxt;
  // upd_ins marks the insert phase of an UPDATE; results then come from the insert outcome
  always_comb begin
    done     = bus.ht_state == 2'd2;
    cur      = &cnt ? cnt : cnt + 16'd1;
    tmr_nxt  = tmr + TW'(1);
    st_done  = (op == OP_INS || upd_ins) ? (bus.ht_success ? ST_OK : ST_FULL)
                                         : (bus.ht_success ? ST_OK : ST_MISS);
    val_done = upd_ins ? old_val
             : op == OP_INS ? (bus.ht_success ? bus.ht_value_in : '0)
             : (bus.ht_success ? bus.ht_value_out : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= S_IDLE;
      op               <= OP_INS;
      upd_ins          <= 1'b0;
      old_val          <= '0;
      cnt              <= '0;
      tmr              <= '0;
      bus.req_ready    <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.resp_status  <= ST_OK;
      bus.resp_value   <= '0;
      bus.resp_cycles  <= '0;
      bus.ht_key       <= '0;
      bus.ht_value_in  <= '0;
      bus.ht_insert    <= 1'b0;
      bus.ht_lookup    <= 1'b0;
      bus.ht_erase     <= 1'b0;
      op_count         <= '0;
      timeout_seen     <= 1'b0;
    end else
      case (state)
        S_IDLE: if (bus.req_valid) begin
          bus.req_ready   <= 1'b0;
          op              <= bus.req_op;
          bus.ht_key      <= bus.req_key;
          bus.ht_value_in <= bus.req_value;
          upd_ins         <= 1'b0;
          state           <= S_ARM;
        end
        S_ARM: if (bus.ht_state == 2'd0) begin
          bus.ht_insert <= op == OP_INS;
          bus.ht_lookup <= op == OP_LK;
          bus.ht_erase  <= op == OP_ER || op == OP_UPD;
          cnt           <= '0;
          tmr           <= '0;
          state         <= S_WAIT;
        end
        S_WAIT: if (done) begin
          bus.ht_insert <= 1'b0;
          bus.ht_lookup <= 1'b0;
          bus.ht_erase  <= 1'b0;
          cnt           <= cur;
          tmr           <= '0;
          if (op == OP_UPD && !upd_ins && bus.ht_success) begin
            upd_ins       <= 1'b1;
            old_val       <= bus.ht_value_out;
            bus.ht_insert <= 1'b1;
          end else begin
            bus.resp_status <= st_done;
            bus.resp_value  <= val_done;
            bus.resp_cycles <= cur;
            state           <= S_RESP;
          end
        end else if (tmr_nxt == TW'(TIMEOUT_CYCLES)) begin
          bus.ht_insert   <= 1'b0;
          bus.ht_lookup   <= 1'b0;
          bus.ht_erase    <= 1'b0;
          bus.resp_status <= ST_TO;
          bus.resp_value  <= '0;
          bus.resp_cycles <= cur;
          timeout_seen    <= 1'b1;
          state           <= S_RESP;
        end else begin
          cnt <= cur;
          tmr <= tmr_nxt;
        end
        S_RESP: if (!bus.resp_valid) bus.resp_valid <= 1'b1;
          else if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            op_count       <= op_count + 32'd1;
            bus.req_ready  <= 1'b1;
            state          <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_ht_cmd_initiator.sv
// tb_ht_cmd_initiator: drives the initiator against a chained hash-table model and checks responses
// against an associative-array reference of the order map.
module tb_ht_cmd_initiator;
  localparam int TO = 8, CAP = 5;
  typedef struct packed { logic [31:0] k; logic [63:0] v; } ent_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [31:0] op_count;
  logic timeout_seen;
  int checks = 0, errors = 0, cmd_total = 0, multi = 0, exp_ops = 0, seq = 0;
  logic exp_to = 1'b0;
  ht_cmd_initiator_if #(.KEY_WIDTH(32), .VALUE_WIDTH(64)) bus ();
  ht_cmd_initiator #(.KEY_WIDTH(32), .VALUE_WIDTH(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .op_count(op_count), .timeout_seen(timeout_seen));
  always #5 clk = ~clk;

  // hash-table model: bucket = key[7:0], chains kept in insertion order
  ent_t tq[$];
  logic [1:0] t_state = 2'd0;
  logic t_succ = 1'b0, stuck = 1'b0;
  logic [63:0] t_val = '0;
  int t_left = 0, idx, pos, blen;
  logic ok;
  assign bus.ht_state = t_state;
  assign bus.ht_success = t_succ;
  assign bus.ht_value_out = t_val;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t_state <= 2'd0;
      t_succ <= 1'b0;
    end else case (t_state)
      2'd0: if (bus.ht_insert | bus.ht_lookup | bus.ht_erase) begin
        if (stuck) begin t_state <= 2'd1; t_left <= 0; end
        else begin
          idx = -1; pos = 0; blen = 0;
          for (int i = 0; i < tq.size(); i++)
            if (tq[i].k[7:0] == bus.ht_key[7:0]) begin
              if (tq[i].k == bus.ht_key) idx = i; else if (idx < 0) pos++;
              blen++;
            end
          if (bus.ht_insert) begin
            ok = idx >= 0 || tq.size() < CAP;
            if (idx >= 0) tq[idx].v = bus.ht_value_in;
            else if (ok) tq.push_back('{k: bus.ht_key, v: bus.ht_value_in});
            t_succ <= ok; t_val <= '0; t_state <= 2'd2;
          end else begin
            t_succ <= idx >= 0;
            t_val <= '0;
            if (idx >= 0) begin
              t_val <= tq[idx].v;
              if (bus.ht_erase) tq.delete(idx);
            end
            t_left <= idx >= 0 ? pos + 1 : (blen > 0 ? blen : 1);
            t_state <= 2'd1;
          end
        end
      end
      2'd1: if (t_left == 0) begin if (!stuck) t_state <= 2'd0; end
            else if (t_left == 1) t_state <= 2'd2;
            else t_left <= t_left - 1;
      default: begin t_state <= 2'd0; t_succ <= 1'b0; end
    endcase

  always @(negedge clk) begin
    cmd_total <= cmd_total + 32'(bus.ht_insert) + 32'(bus.ht_lookup) + 32'(bus.ht_erase);
    if (32'(bus.ht_insert) + 32'(bus.ht_lookup) + 32'(bus.ht_erase) > 1) multi <= multi + 1;
  end

  // reference order map: value and insertion sequence per key
  logic [63:0] rv [logic [31:0]];
  int rs [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expired(input string tag);
    checks++; errors++;
    $error("FAIL %s wait bound expired", tag);
  endtask

  task automatic model(input logic [1:0] o, input logic [31:0] k, input logic [63:0] v,
                       output logic [1:0] st, output logic [63:0] val, output int cyc);
    bit hit = rv.exists(k);
    int p = 0, b = 0, srch;
    foreach (rs[x]) if (x[7:0] == k[7:0]) begin
      b++;
      if (hit && rs[x] < rs[k]) p++;
    end
    srch = hit ? p + 1 : (b > 0 ? b : 1);
    st = 2'd1; val = '0; cyc = srch + 2;
    case (o)
      2'd0: begin
        cyc = 2;
        if (hit || rv.num() < CAP) begin
          if (!hit) rs[k] = seq++;
          rv[k] = v; st = 2'd0; val = v;
        end else st = 2'd2;
      end
      2'd3: if (hit) begin
        val = rv[k]; st = 2'd0; cyc = srch + 4;
        rv[k] = v; rs[k] = seq++;
      end
      default: if (hit) begin
        st = 2'd0; val = rv[k];
        if (o == 2'd2) begin rv.delete(k); rs.delete(k); end
      end
    endcase
  endtask

  task automatic xact(input logic [1:0] o, input logic [31:0] k, input logic [63:0] v,
                      input int hold, input bit chk_lat, input bit force_to);
    logic [1:0] es; logic [63:0] ev; int ec, c0, lat, n;
    if (force_to) begin es = 2'd3; ev = '0; ec = TO; exp_to = 1'b1; end
    else model(o, k, v, es, ev, ec);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = o; bus.req_key = k; bus.req_value = v;
    n = 0;
    while (!bus.req_ready) begin
      @(negedge clk);
      if (++n > 100) begin expired("accept"); bus.req_valid = 1'b0; return; end
    end
    c0 = cmd_total;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    chk("busy_req_ready", bus.req_ready, 0);
    lat = 0;
    while (!bus.resp_valid) begin
      @(posedge clk); #1 lat++;
      if (lat > 200) begin expired("resp_valid"); return; end
    end
    chk("resp_status", bus.resp_status, es);
    chk("resp_value", bus.resp_value, ev);
    chk("resp_cycles", bus.resp_cycles, ec);
    chk("cmd_high_cycles", cmd_total - c0, ec);
    if (chk_lat) chk("latency", lat, ec + 2);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("held_valid", bus.resp_valid, 1);
      chk("held_status", bus.resp_status, es);
      chk("held_value", bus.resp_value, ev);
      chk("held_req_ready", bus.req_ready, 0);
      chk("held_op_count", op_count, exp_ops);
    end
    @(negedge clk) bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.resp_ready = 1'b0;
    exp_ops++;
    chk("op_count", op_count, exp_ops);
    chk("resp_valid_drop", bus.resp_valid, 0);
    chk("req_ready_back", bus.req_ready, 1);
    chk("timeout_seen", timeout_seen, exp_to);
  endtask

  logic [31:0] pool [7] = '{32'h10, 32'h2010, 32'h4010, 32'h6010, 32'h20, 32'h2020, 32'h8020};

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    bus.req_op = '0; bus.req_key = '0; bus.req_value = '0;
    #2 rst_n = 1'b0;
    #1 chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_cmds", {bus.ht_insert, bus.ht_lookup, bus.ht_erase}, 0);
    chk("rst_op_count", op_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_timeout_seen", timeout_seen, 0);
    // directed: insert, hit/miss lookups, update then lookup
    xact(2'd0, 32'h10, 64'hAA, 0, 1, 0);
    xact(2'd1, 32'h10, 64'h0, 0, 1, 0);
    xact(2'd1, 32'h2010, 64'h0, 0, 1, 0);
    xact(2'd3, 32'h10, 64'hBB, 0, 1, 0);
    xact(2'd1, 32'h10, 64'h0, 0, 1, 0);
    // randomized order-map traffic over a small key pool so chains and FULL occur
    for (int i = 0; i < 40; i++)
      xact(2'($urandom_range(0, 3)), pool[$urandom_range(0, 6)], {$urandom, $urandom}, 0, 1, 0);
    // fill the table and hold a FULL response
    for (int i = 0; i < 10 && rv.num() < CAP; i++)
      xact(2'd0, 32'h100 + (i << 12), {32'h0, $urandom}, 0, 1, 0);
    xact(2'd0, 32'hABCD, 64'h1234, 5, 1, 0);
    // stuck table: timeout, then a request that waits in arm until the table idles
    stuck = 1'b1;
    xact(2'd1, 32'h10, 64'h0, 0, 1, 1);
    fork
      xact(2'd1, 32'h2020, 64'h0, 0, 0, 0);
      begin
        repeat (10) @(negedge clk);
        chk("arm_wait_cmds", {bus.ht_insert, bus.ht_lookup, bus.ht_erase}, 0);
        stuck = 1'b0;
      end
    join
    // asynchronous reset in the middle of a lookup
    stuck = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_key = 32'h10;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    n = 0;
    while (!bus.ht_lookup && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) expired("lookup_rise");
    #3 rst_n = 1'b0;
    #1 chk("midrst_cmds", {bus.ht_insert, bus.ht_lookup, bus.ht_erase}, 0);
    chk("midrst_key", bus.ht_key, 0);
    chk("midrst_resp_value", bus.resp_value, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_timeout_seen", timeout_seen, 0);
    stuck = 1'b0; exp_ops = 0; exp_to = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_req_ready", bus.req_ready, 1);
    xact(2'd1, 32'h10, 64'h0, 0, 1, 0);
    chk("onehot", multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation did not terminate");
  end
endmodule
